// File: rtl/bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// bcd_scan_decoder
//
// Captures a packed multi-digit BCD word and scans it one digit at a time
// onto a single one-hot decimal bus. Each digit slot is held for SCAN_DIV
// clocks. A new word is staged in a shadow register and only copied to the
// displayed (active) register at the end of a full frame, so a frame never
// mixes old and new digits.
//
// Parameters:
//   DIGITS   - number of BCD digits (1..8), digit 0 is bcd_in[3:0]
//   SCAN_DIV - clocks per digit slot (>= 1)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   capture bcd_in into the shadow register
//   bcd_in   in   packed BCD word, nibble k is digit k
//   lz_blank in   enable leading-zero blanking (sampled every clock)
//   err_clr  in   clear the sticky error flag
//   d_out    out  one-hot decimal value of the current digit
//   dig_sel  out  one-hot select of the current digit slot
//   err      out  sticky flag, a loaded word contained a nibble above 9
// ---------------------------------------------------------------------------
module bcd_scan_decoder #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  lz_blank,
    input  logic                  err_clr,
    output logic [9:0]            d_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  err
);

    // Counter widths are kept at least one bit so SCAN_DIV=1 / DIGITS=1 work.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   active;

    logic                  tc;
    logic                  wrap;
    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic                  in_invalid;
    logic                  zero_run;
    logic [9:0]            dec;
    logic [DIGITS-1:0]     sel;

    assign tc   = (prescaler == PS_LAST);
    assign wrap = tc && (idx == IDX_LAST);

    // Digit selection, blanking and decode for the slot currently indexed.
    // The zero run is accumulated from the most significant digit down, so a
    // digit is blankable only when it and every digit above it are zero.
    // Digit 0 is never blankable, which keeps a value of zero visible.
    always_comb begin
        cur_nib   = 4'd0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        sel       = '0;
        dec       = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (active[4*k +: 4] == 4'd0);
            if (idx == IW'(k)) begin
                cur_nib   = active[4*k +: 4];
                cur_blank = lz_blank && (k > 0) && zero_run;
                sel[k]    = 1'b1;
            end
        end
        // Codes 10..15 fall through with no line set.
        for (int v = 0; v < 10; v++) begin
            if (cur_nib == 4'(v)) begin
                dec[v] = 1'b1;
            end
        end
    end

    // Any nibble of the incoming word above 9 marks the load as invalid.
    always_comb begin
        in_invalid = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                in_invalid = 1'b1;
            end
        end
    end

    // Scan counters, double buffer, sticky error and registered outputs.
    // On a wrap edge with a simultaneous load the incoming word goes straight
    // to the active register so the newest value is the one displayed next.
    // An invalid load takes priority over err_clr on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
            shadow    <= '0;
            active    <= '0;
            err       <= 1'b0;
            d_out     <= '0;
            dig_sel   <= '0;
        end else begin
            if (tc) begin
                prescaler <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            if (load) begin
                shadow <= bcd_in;
            end

            if (wrap) begin
                active <= load ? bcd_in : shadow;
            end

            if (load && in_invalid) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            d_out   <= cur_blank ? 10'd0 : dec;
            dig_sel <= cur_blank ? '0 : sel;
        end
    end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_decoder
//
// Directed bench for bcd_scan_decoder with DIGITS=4, SCAN_DIV=4 (one frame is
// 16 clocks). A small reference model of the shadow/active registers and the
// error flag produces the expected d_out, dig_sel and err after every edge.
// ---------------------------------------------------------------------------
module tb_bcd_scan_decoder;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic        lz_blank;
    logic        err_clr;
    logic [9:0]  d_out;
    logic [3:0]  dig_sel;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic        m_err;

    bcd_scan_decoder #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bcd_in   (bcd_in),
        .lz_blank (lz_blank),
        .err_clr  (err_clr),
        .d_out    (d_out),
        .dig_sel  (dig_sel),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h",
                   tag, edges, observed, expected);
        end
    endtask

    function automatic logic has_invalid(input logic [15:0] w);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Drive inputs for one clock edge, advance the model, then check outputs
    // 2 ns after the edge.
    task automatic applyStimulus(input logic ld, input logic [15:0] bcd,
                                 input logic clr);
        int         slot;
        logic       blank;
        logic [3:0] nib;
        logic [3:0] e_sel;
        logic [9:0] e_d;
        load    = ld;
        bcd_in  = bcd;
        err_clr = clr;
        @(posedge clk);
        edges++;
        slot  = ((edges - 1) / SCAN_DIV) % DIGITS;
        nib   = m_active[4*slot +: 4];
        blank = lz_blank && (slot > 0) && ((m_active >> (4*slot)) == 16'd0);
        e_sel = blank ? 4'd0 : 4'(1 << slot);
        e_d   = (blank || nib > 4'd9) ? 10'd0 : 10'(1 << nib);
        if (ld && has_invalid(bcd)) m_err = 1'b1;
        else if (clr)               m_err = 1'b0;
        if (edges % FRAME == 0) m_active = ld ? bcd : m_shadow;
        if (ld) m_shadow = bcd;
        #2;
        checkOutput("d_out", 32'(d_out), 32'(e_d));
        checkOutput("dig_sel", 32'(dig_sel), 32'(e_sel));
        checkOutput("err", 32'(err), 32'(m_err));
        load    = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, bcd_in, 1'b0);
    endtask

    // Idle until the edge count within the frame reaches pos.
    task automatic align(input int pos);
        while (edges % FRAME != pos) applyStimulus(1'b0, bcd_in, 1'b0);
    endtask

    task automatic reset_model();
        edges    = 0;
        m_shadow = 16'h0;
        m_active = 16'h0;
        m_err    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = 16'h0;
        lz_blank = 1'b0;
        err_clr  = 1'b0;
        reset_model();

        // Outputs held at zero while in reset, even across a clock edge.
        #12;
        checkOutput("reset_d_out", 32'(d_out), 32'h0);
        checkOutput("reset_dig_sel", 32'(dig_sel), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] scan after reset release");
        idle(FRAME + 1);

        $display("[TB] mid-frame load of 1234");
        align(5);
        applyStimulus(1'b1, 16'h1234, 1'b0);
        align(0);
        idle(FRAME);

        $display("[TB] leading-zero blanking");
        lz_blank = 1'b1;
        align(8);
        applyStimulus(1'b1, 16'h0045, 1'b0);
        align(0);
        idle(FRAME);
        align(8);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        align(0);
        idle(FRAME);
        align(8);
        applyStimulus(1'b1, 16'h0405, 1'b0);
        align(0);
        idle(FRAME);

        $display("[TB] invalid code and error flag");
        lz_blank = 1'b0;
        align(8);
        applyStimulus(1'b1, 16'h12A4, 1'b0);
        align(0);
        idle(FRAME);
        applyStimulus(1'b0, 16'h12A4, 1'b1);
        applyStimulus(1'b1, 16'h00B0, 1'b1);
        idle(2);
        applyStimulus(1'b0, 16'h00B0, 1'b1);
        idle(3);

        $display("[TB] asynchronous reset mid-scan");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_d_out", 32'(d_out), 32'h0);
        checkOutput("async_dig_sel", 32'(dig_sel), 32'h0);
        checkOutput("async_err", 32'(err), 32'h0);
        @(posedge clk);
        #2;
        checkOutput("held_d_out", 32'(d_out), 32'h0);
        checkOutput("held_dig_sel", 32'(dig_sel), 32'h0);
        rst_n = 1'b1;
        reset_model();
        bcd_in = 16'h0;
        idle(FRAME);

        $display("[TB] digit sweep loaded on wrap edges");
        for (int v = 0; v < 10; v++) begin
            align(FRAME - 1);
            applyStimulus(1'b1, 16'(v), 1'b0);
        end
        idle(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
